// File: rtl/ssd_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan path.
package ssd_pkg;

    localparam int SSD_NIBBLE_W   = 4;
    localparam int SSD_MAX_DIGITS = 8;

    // Wide enough for the largest digit count; users slice the low N_DIGITS bits.
    localparam logic [SSD_MAX_DIGITS-1:0] SSD_ANODE_OFF = 8'hFF;

    typedef enum logic [0:0] {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot counter and digit index for the scanner; derives the blank/show phase
// of each slot and the end-of-frame pulse.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8,
    localparam int CNT_W       = $clog2(REFRESH_DIV),
    localparam int IDX_W       = $clog2(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output slot_state_e      slot_state,
    output logic [IDX_W-1:0] idx,
    output logic             frame_tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             cnt_wrap_s;
    logic             last_digit_s;

    // Next-state for the slot counter and digit index, plus phase decode.
    always_comb begin
        cnt_wrap_s   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_digit_s = (idx_q == IDX_W'(N_DIGITS - 1));
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        if (cnt_wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            if (last_digit_s) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q < CNT_W'(BLANK_CYCLES)) begin
            slot_state = SLOT_BLANK;
        end else begin
            slot_state = SLOT_SHOW;
        end
        idx        = idx_q;
        frame_tick = cnt_wrap_s && last_digit_s;
    end

    // Counter and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed hex digit scanner: frame-synchronous value commit, blanking
// gap between digits, leading-zero suppression and active-low anode select.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4*N_DIGITS-1:0]        value_in,
    input  logic                         load,
    input  logic                         display_on,
    output logic [SSD_NIBBLE_W-1:0]      digit_bin,
    output logic                         digit_en,
    output logic [N_DIGITS-1:0]          anode_n,
    output logic                         frame_tick
);

    localparam int VAL_W = SSD_NIBBLE_W * N_DIGITS;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [N_DIGITS-1:0] ANODE_OFF = SSD_ANODE_OFF[N_DIGITS-1:0];

    logic [VAL_W-1:0]        pending_q, pending_d;
    logic [VAL_W-1:0]        disp_q, disp_d;
    logic                    on_q, on_d;

    slot_state_e             slot_state_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    frame_tick_s;

    logic [N_DIGITS-1:0]     lz_s;
    logic                    zero_above_s;
    logic [SSD_NIBBLE_W-1:0] nib_sel_s;
    logic                    suppress_s;
    logic                    lit_s;

    ssd_slot_timer #(
        .N_DIGITS     (N_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot_state (slot_state_s),
        .idx        (idx_s),
        .frame_tick (frame_tick_s)
    );

    // Load capture and frame-boundary commit; disp always takes pre-edge pending.
    always_comb begin
        pending_d = pending_q;
        disp_d    = disp_q;
        on_d      = display_on;
        if (load) begin
            pending_d = value_in;
        end else begin
            pending_d = pending_q;
        end
        if (frame_tick_s) begin
            disp_d = pending_q;
        end else begin
            disp_d = disp_q;
        end
    end

    // Value and display-enable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= {VAL_W{1'b0}};
            disp_q    <= {VAL_W{1'b0}};
            on_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            disp_q    <= disp_d;
            on_q      <= on_d;
        end
    end

    // Output decode from registered state only; lz_s[i] means digits i..N-1 are all zero.
    always_comb begin
        lz_s         = {N_DIGITS{1'b0}};
        zero_above_s = 1'b1;
        nib_sel_s    = {SSD_NIBBLE_W{1'b0}};
        suppress_s   = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s &&
                           (disp_q[SSD_NIBBLE_W*i +: SSD_NIBBLE_W] == 4'h0);
            lz_s[i]      = zero_above_s;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_s == IDX_W'(i)) begin
                nib_sel_s  = disp_q[SSD_NIBBLE_W*i +: SSD_NIBBLE_W];
                suppress_s = (LZ_SUPPRESS != 0) && (i != 0) && lz_s[i];
            end else begin
                nib_sel_s  = nib_sel_s;
                suppress_s = suppress_s;
            end
        end
        lit_s = (slot_state_s == SLOT_SHOW) && on_q && !suppress_s;

        anode_n = ANODE_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            anode_n[i] = !(lit_s && (idx_s == IDX_W'(i)));
        end
        digit_bin  = nib_sel_s;
        digit_en   = lit_s;
        frame_tick = frame_tick_s;
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: stimulus queues expected lit runs, a
// monitor measures each run of digit_en and compares it against the queue.
module tb_ssd_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        display_on;
    logic [3:0]  digit_bin;
    logic        digit_en;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bin;
        int         len;
    } rec_t;

    rec_t exp_q[$];

    ssd_scan_mux #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (10),
        .BLANK_CYCLES (2),
        .LZ_SUPPRESS  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .display_on (display_on),
        .digit_bin  (digit_bin),
        .digit_en   (digit_en),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic exp_run(input logic [3:0] an, input logic [3:0] bin, input int len);
        rec_t r;
        r.an  = an;
        r.bin = bin;
        r.len = len;
        exp_q.push_back(r);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic at(input int k);
        int n = 0;
        while (cyc < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < k) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for cycle %0d, at %0d", k, cyc);
        end
    endtask

    task automatic load_v(input int k, input logic [15:0] v);
        at(k);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: frame_tick cadence, dark anodes, and lit-run scoreboard.
    logic       in_run = 1'b0;
    logic [3:0] run_an;
    logic [3:0] run_bin;
    int         run_len;
    rec_t       e;

    always @(negedge clk) begin
        checks++;
        if (frame_tick !== ((cyc % 40) == 39)) begin
            errors++;
            $display("FAIL frame_tick: got %b expected %b (cyc %0d)",
                     frame_tick, ((cyc % 40) == 39), cyc);
        end
        if (digit_en === 1'b1) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_an  = anode_n;
                run_bin = digit_bin;
                run_len = 1;
            end else begin
                run_len++;
            end
        end else begin
            checks++;
            if (anode_n !== 4'hF) begin
                errors++;
                $display("FAIL dark_anodes: got %b expected 1111 (cyc %0d)", anode_n, cyc);
            end
            if (in_run) begin
                in_run = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_run: got an=%b bin=%h len=%0d expected none",
                             run_an, run_bin, run_len);
                end else begin
                    e = exp_q.pop_front();
                    if (run_an !== e.an || run_bin !== e.bin || run_len != e.len) begin
                        errors++;
                        $display("FAIL lit_run: got an=%b bin=%h len=%0d expected an=%b bin=%h len=%0d (cyc %0d)",
                                 run_an, run_bin, run_len, e.an, e.bin, e.len, cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value_in   = 16'h0000;
        display_on = 1'b1;
        #1;
        chk("reset_anode_n",    {12'h000, anode_n},    16'h000F);
        chk("reset_digit_en",   {15'h0000, digit_en},  16'h0000);
        chk("reset_digit_bin",  {12'h000, digit_bin},  16'h0000);
        chk("reset_frame_tick", {15'h0000, frame_tick}, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frame 0 shows the reset value: only digit 0, reading 0.
        exp_run(4'hE, 4'h0, 8);
        load_v(1, 16'h1234);
        exp_run(4'hE, 4'h4, 8); exp_run(4'hD, 4'h3, 8);
        exp_run(4'hB, 4'h2, 8); exp_run(4'h7, 4'h1, 8);

        load_v(45, 16'h0050);
        exp_run(4'hE, 4'h0, 8); exp_run(4'hD, 4'h5, 8);

        load_v(85, 16'h0000);
        exp_run(4'hE, 4'h0, 8);

        load_v(125, 16'h1000);
        exp_run(4'hE, 4'h0, 8); exp_run(4'hD, 4'h0, 8);
        exp_run(4'hB, 4'h0, 8); exp_run(4'h7, 4'h1, 8);

        // Back-to-back loads: the later one is committed.
        load_v(170, 16'h9999);
        load_v(171, 16'h5555);
        exp_run(4'hE, 4'h5, 8); exp_run(4'hD, 4'h5, 8);
        exp_run(4'hB, 4'h5, 8); exp_run(4'h7, 4'h5, 8);

        // Load on the frame_tick cycle lands one frame later.
        load_v(199, 16'hABCD);
        exp_run(4'hE, 4'hD, 8);
        exp_run(4'hD, 4'hC, 3);
        exp_run(4'hD, 4'hC, 3);
        exp_run(4'hB, 4'hB, 8); exp_run(4'h7, 4'hA, 8);

        at(254);
        display_on = 1'b0;
        @(negedge clk);
        chk("on_drop_anode_n",  {12'h000, anode_n},   16'h000F);
        chk("on_drop_digit_en", {15'h0000, digit_en}, 16'h0000);
        at(256);
        display_on = 1'b1;

        exp_run(4'hE, 4'hD, 8); exp_run(4'hD, 4'hC, 8);

        // Reset in the middle of digit 2's SHOW phase.
        at(304);
        exp_run(4'hB, 4'hB, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_anode_n",  {12'h000, anode_n},   16'h000F);
        chk("async_rst_digit_en", {15'h0000, digit_en}, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_run(4'hE, 4'h0, 8);

        at(45);
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
Time-multiplexed digit scanner that sits directly upstream of ssd_driver on the multi-digit display path. It holds an N-digit hex value and cycles through the digits one refresh slot at a time. For each slot it presents the selected nibble and an enable to ssd_driver (binary_in/enable) and drives the active-low digit anodes. It also inserts a blanking gap between digits to prevent ghosting, suppresses leading zeros, and applies new values only at frame boundaries so the display never tears.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 8, cycles at the start of each slot with every digit dark (>= 1)
LZ_SUPPRESS, 1, 1 = blank leading zero digits (digit 0 is always shown)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
value_in  in  4*N_DIGITS  hex value; nibble i drives digit i, digit 0 is least significant
load  in  1  single-cycle strobe; captures value_in into the pending register
display_on  in  1  0 = all digits dark; the counters keep running
digit_bin  out  4  nibble for the active digit; connects to ssd_driver binary_in
digit_en  out  1  connects to ssd_driver enable
anode_n  out  N_DIGITS  one-hot, active-low digit select
frame_tick  out  1  one-cycle pulse on the last cycle of digit N-1's slot

Behaviour:
- Reset: clock and reset are fixed as above; rst is asynchronous and active-high. Reset clears all of the following:
  - cnt=0, idx=0, pending=0, disp=0, on_q=0
  - anode_n=all 1, digit_en=0, digit_bin=0, frame_tick=0
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, idx advances; N_DIGITS-1 wraps to 0.
- State is derived from cnt:
  - BLANK when cnt < BLANK_CYCLES.
  - SHOW otherwise.
- Outputs are a combinational decode of registers only (cnt, idx, disp, on_q). There is no input-to-output combinational path.
- display_on is registered into on_q, so it takes effect 1 cycle after it is sampled.
- Digit i is lit when all of these hold:
  - state == SHOW
  - on_q == 1
  - idx == i
  - not (LZ_SUPPRESS && i != 0 && disp[4*N-1 : 4*i] == 0)
- While lit: anode_n[idx]=0, other anodes 1, digit_en=1, digit_bin=disp[4*idx +: 4].
- While not lit: anode_n=all 1, digit_en=0, digit_bin=disp[4*idx +: 4] (don't-care to ssd_driver, but deterministic).
- frame_tick=1 iff cnt==REFRESH_DIV-1 and idx==N_DIGITS-1.
- Load and commit:
  - load=1 writes value_in into pending on that edge.
  - On each frame_tick edge, disp takes pending's pre-edge value.
  - If load and frame_tick coincide, disp takes the old pending value and the new value is applied one frame later.
  - Back-to-back loads: the last one before commit wins.
- No handshake back-pressure: load is always accepted.
- Reset mid-slot immediately darks all digits, and scanning restarts at digit 0 in BLANK.

Decomposition:
- Package ssd_pkg holds:
  - SSD_NIBBLE_W=4
  - the anode-off constant (all ones)
  - the slot state enum {SLOT_BLANK, SLOT_SHOW}
- One sub-module, ssd_slot_timer: holds cnt and idx and emits slot_state, idx and frame_tick.
- ssd_scan_mux adds the pending/disp registers, the display_on flop, zero suppression and the output decode.
- ssd_driver is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=10, BLANK_CYCLES=2, LZ_SUPPRESS=1.
1. Reset with load=0x1234 during frame 0, display_on=1 -> frame 0 shows all digits dark and digit 0 reading 0. From frame 1, each slot has 2 dark cycles then 8 cycles of digit_bin=4,3,2,1 with anode_n=1110,1101,1011,0111. frame_tick pulses every 40 cycles.
2. Load 0x0050 -> digits 3 and 2 are dark (digit_en=0, anode_n=1111). Digit 1 shows 5 and digit 0 shows 0.
3. Load 0x0000 -> only digit 0 is lit and shows 0. Loading 0x1000 -> all four digits are lit.
4. Load 0xABCD asserted on the same cycle as frame_tick -> the frame after the tick still shows the old value. 0xABCD appears one frame later.
5. display_on dropped mid-SHOW -> anode_n=1111 one cycle later. Raising it resumes on the current slot with no change to the counters.
6. rst pulsed mid-slot of digit 2 -> outputs dark asynchronously. After release: idx=0, cnt=0, disp=0.
